ex_stage: RTL and testbench
===========================

# ex_stage

Execute stage of the five-stage pipeline. Consumes the decoded operands and control bits held in the ID/EX pipeline register and computes the ALU result. Multiply/divide/remainder run on an iterative 32-step unit; while it runs, the block stalls everything upstream. Results and pass-through control are registered into the EX/MEM register that feeds the memory stage.

## Interface
Parameters:
- none (datapath fixed at 32 bits, register index 5 bits)

Ports:
- clk_i  in  1  clock, all state on rising edge
- rst_i  in  1  reset, synchronous, active-high
- flush_i  in  1  squash the instruction currently in EX (hazard/branch unit)
- pc_i  in  32  PC of instruction in EX
- ram_we_i  in  1  store enable
- wR_i  in  5  destination register
- rf_wsel_i  in  2  writeback source select
- rf_we_i  in  1  register-file write enable
- alu_op_i  in  4  operation code
- alua_i, alub_i  in  32  ALU operands
- ext_i  in  32  immediate
- rD2_i  in  32  store data
- pause_o  out  1  combinational stall request to IF/ID and ID/EX registers
- pc_o, ram_we_o, wR_o, rf_wsel_o, rf_we_o, ext_o, rD2_o  out  as inputs  registered pass-through
- alu_c_o  out  32  registered result

## Operation
- alu_op codes:
  - 0 ADD; 1 SUB; 2 AND; 3 OR; 4 XOR
  - 5 SLL, 6 SRL, 7 SRA (shift amount alub[4:0])
  - 8 SLT (signed), 9 SLTU (result 0/1)
  - A MUL (low 32 bits); B DIV (signed); C DIVU; D REM (signed); E REMU
  - F pass alub
- Codes 0–9 and F are single-cycle.
- Codes A–E are multi-cycle.
- Iterative-unit FSM states: IDLE, BUSY, DONE.
  - IDLE → BUSY: multi-cycle op present and flush_i=0. Operands are latched; signed ops latch magnitudes plus result-sign flags; step counter is cleared.
  - BUSY: one shift-add (MUL) or restoring-subtract (DIV/REM) step per cycle. After step 31 (counter wraps 31→0), go to DONE.
  - DONE: final sign correction is applied, then return to IDLE at the next edge.
- pause_o = multi-cycle op at input && state≠DONE && flush_i=0. It is asserted in IDLE the same cycle the op arrives, so ID/EX holds its operands for the full run.
- EX/MEM register load rules, each edge, in priority order:
  1. rst_i: all outputs 0.
  2. flush_i or pause_o: bubble. All outputs 0; in particular rf_we_o=0 and ram_we_o=0.
  3. Otherwise: load inputs. alu_c_o takes the single-cycle result, or the iterative result in DONE.
- Divide boundary rules (RISC-V):
  - Divisor 0: DIV/DIVU quotient 32'hFFFFFFFF; REM/REMU remainder = dividend. Still takes the full 33+1 cycles.
  - DIV 32'h80000000 / 32'hFFFFFFFF: quotient 32'h80000000, REM result 0.
  - Remainder sign follows the dividend.
- All arithmetic wraps mod 2^32; no overflow flags.

## Timing
- Reset values: pause_o=0, FSM=IDLE, counter=0, all registered outputs 0.
- Single-cycle op: inputs in cycle n → outputs valid after edge ending cycle n.
- Multi-cycle op arriving in cycle 0:
  - pause_o high in cycles 0–32 (IDLE + 32 BUSY).
  - DONE in cycle 33 with pause_o=0.
  - Result visible after the edge ending cycle 33.
  - EX/MEM carries bubbles during cycles 0–32.
  - Total latency: 34 cycles.
- Back-to-back multi-cycle ops: the FSM returns to IDLE after DONE, and the next op starts on the following cycle. No op is lost or merged.
- flush_i while BUSY: the FSM aborts to IDLE at that edge, pause_o drops combinationally the same cycle, and a bubble is loaded.
- rst_i mid-operation: the same abort applies; no partial result is ever emitted.

## Test plan
- ADD 5+7 with rf_we_i=1, wR_i=3 → next edge: alu_c_o=12, wR_o=3, rf_we_o=1, pause_o never high.
- SRA 32'h80000000 by 4; SLTU 1 < 32'hFFFFFFFF → 32'hF8000000; 1.
- DIV −7/2 arriving cycle 0 → pause_o high cycles 0–32; bubbles (rf_we_o=0) through cycle 33's edge−1; then alu_c_o=32'hFFFFFFFD. REM −7/2 gives 32'hFFFFFFFF.
- DIVU 9/0 → 32'hFFFFFFFF; REMU 9/0 → 9. DIV 32'h80000000/−1 → 32'h80000000.
- MUL 32'h10000/32'h10000 → 0; MUL 123×−2 → 32'hFFFFFF0A, latency 34.
- Start DIV, assert flush_i in BUSY cycle 10 → pause_o low that cycle, bubble loaded, FSM IDLE. Repeat with rst_i → all outputs 0. A following ADD completes normally.

Source files
------------

// File: rtl/ex_stage.sv
// Execute stage: single-cycle ALU plus a 32-step iterative mul/div unit,
// registered into the EX/MEM pipeline register.
module ex_stage (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        flush_i,
    input  logic [31:0] pc_i,
    input  logic        ram_we_i,
    input  logic [4:0]  wR_i,
    input  logic [1:0]  rf_wsel_i,
    input  logic        rf_we_i,
    input  logic [3:0]  alu_op_i,
    input  logic [31:0] alua_i,
    input  logic [31:0] alub_i,
    input  logic [31:0] ext_i,
    input  logic [31:0] rD2_i,
    output logic        pause_o,
    output logic [31:0] pc_o,
    output logic        ram_we_o,
    output logic [4:0]  wR_o,
    output logic [1:0]  rf_wsel_o,
    output logic        rf_we_o,
    output logic [31:0] ext_o,
    output logic [31:0] rD2_o,
    output logic [31:0] alu_c_o
);
    localparam logic [3:0] OP_MUL  = 4'hA;
    localparam logic [3:0] OP_DIV  = 4'hB;
    localparam logic [3:0] OP_DIVU = 4'hC;
    localparam logic [3:0] OP_REM  = 4'hD;
    localparam logic [3:0] OP_REMU = 4'hE;

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
    state_t state_q, state_d;

    logic        is_mc;
    logic [31:0] alu_res;
    logic [31:0] iter_res;
    logic        signed_op;
    logic [31:0] a_mag, b_mag;
    logic [4:0]  cnt;
    logic [31:0] acc, dvs, quo;
    logic [3:0]  op_q;
    logic        q_neg, r_neg, div_zero;
    logic [32:0] r_sh, diff;

    assign is_mc   = (alu_op_i >= OP_MUL) && (alu_op_i <= OP_REMU);
    assign pause_o = is_mc && (state_q != DONE) && !flush_i;

    always_comb begin
        alu_res = 32'h0;
        case (alu_op_i)
            4'h0: alu_res = alua_i + alub_i;
            4'h1: alu_res = alua_i - alub_i;
            4'h2: alu_res = alua_i & alub_i;
            4'h3: alu_res = alua_i | alub_i;
            4'h4: alu_res = alua_i ^ alub_i;
            4'h5: alu_res = alua_i << alub_i[4:0];
            4'h6: alu_res = alua_i >> alub_i[4:0];
            4'h7: alu_res = $unsigned($signed(alua_i) >>> alub_i[4:0]);
            4'h8: alu_res = {31'h0, $signed(alua_i) < $signed(alub_i)};
            4'h9: alu_res = {31'h0, alua_i < alub_i};
            4'hF: alu_res = alub_i;
            default: alu_res = 32'h0;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) state_q <= IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: if (is_mc && !flush_i) state_d = BUSY;
            BUSY: begin
                if (flush_i)            state_d = IDLE;
                else if (cnt == 5'd31)  state_d = DONE;
            end
            DONE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Signed divide works on magnitudes; signs are restored in DONE.
    always_comb begin
        signed_op = (alu_op_i == OP_DIV) || (alu_op_i == OP_REM);
        a_mag = (signed_op && alua_i[31]) ? -alua_i : alua_i;
        b_mag = (signed_op && alub_i[31]) ? -alub_i : alub_i;
    end

    assign r_sh = {acc, quo[31]};
    assign diff = r_sh - {1'b0, dvs};

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt      <= 5'd0;
            acc      <= 32'h0;
            dvs      <= 32'h0;
            quo      <= 32'h0;
            op_q     <= 4'h0;
            q_neg    <= 1'b0;
            r_neg    <= 1'b0;
            div_zero <= 1'b0;
        end else if (state_q == IDLE) begin
            if (state_d == BUSY) begin
                cnt      <= 5'd0;
                acc      <= 32'h0;
                op_q     <= alu_op_i;
                dvs      <= (alu_op_i == OP_MUL) ? a_mag : b_mag;
                quo      <= (alu_op_i == OP_MUL) ? b_mag : a_mag;
                q_neg    <= signed_op && (alua_i[31] ^ alub_i[31]);
                r_neg    <= signed_op && alua_i[31];
                div_zero <= (alub_i == 32'h0);
            end
        end else if (state_q == BUSY) begin
            cnt <= cnt + 5'd1;
            if (op_q == OP_MUL) begin
                if (quo[0]) acc <= acc + dvs;
                dvs <= dvs << 1;
                quo <= quo >> 1;
            end else if (!diff[32]) begin
                acc <= diff[31:0];
                quo <= {quo[30:0], 1'b1};
            end else begin
                acc <= r_sh[31:0];
                quo <= {quo[30:0], 1'b0};
            end
        end
    end

    // A zero divisor already yields all-ones quotient; keep it unsigned.
    always_comb begin
        iter_res = 32'h0;
        case (op_q)
            OP_MUL:  iter_res = acc;
            OP_DIV:  iter_res = (q_neg && !div_zero) ? -quo : quo;
            OP_DIVU: iter_res = quo;
            OP_REM:  iter_res = r_neg ? -acc : acc;
            OP_REMU: iter_res = acc;
            default: iter_res = 32'h0;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i || flush_i || pause_o) begin
            pc_o      <= 32'h0;
            ram_we_o  <= 1'b0;
            wR_o      <= 5'h0;
            rf_wsel_o <= 2'h0;
            rf_we_o   <= 1'b0;
            ext_o     <= 32'h0;
            rD2_o     <= 32'h0;
            alu_c_o   <= 32'h0;
        end else begin
            pc_o      <= pc_i;
            ram_we_o  <= ram_we_i;
            wR_o      <= wR_i;
            rf_wsel_o <= rf_wsel_i;
            rf_we_o   <= rf_we_i;
            ext_o     <= ext_i;
            rD2_o     <= rD2_i;
            alu_c_o   <= (state_q == DONE) ? iter_res : alu_res;
        end
    end
endmodule

// File: tb/tb_ex_stage.sv
// Self-checking bench for ex_stage: directed boundary cases plus random ops
// against an arithmetic reference model.
module tb_ex_stage;
    logic        clk_i = 1'b0;
    logic        rst_i, flush_i, ram_we_i, rf_we_i;
    logic [31:0] pc_i, alua_i, alub_i, ext_i, rD2_i;
    logic [4:0]  wR_i;
    logic [1:0]  rf_wsel_i;
    logic [3:0]  alu_op_i;
    logic        pause_o, ram_we_o, rf_we_o;
    logic [31:0] pc_o, ext_o, rD2_o, alu_c_o;
    logic [4:0]  wR_o;
    logic [1:0]  rf_wsel_o;

    int checks = 0;
    int failures = 0;

    always #5 clk_i = ~clk_i;

    ex_stage dut (
        .clk_i(clk_i), .rst_i(rst_i), .flush_i(flush_i), .pc_i(pc_i),
        .ram_we_i(ram_we_i), .wR_i(wR_i), .rf_wsel_i(rf_wsel_i), .rf_we_i(rf_we_i),
        .alu_op_i(alu_op_i), .alua_i(alua_i), .alub_i(alub_i), .ext_i(ext_i),
        .rD2_i(rD2_i), .pause_o(pause_o), .pc_o(pc_o), .ram_we_o(ram_we_o),
        .wR_o(wR_o), .rf_wsel_o(rf_wsel_o), .rf_we_o(rf_we_o), .ext_o(ext_o),
        .rD2_o(rD2_o), .alu_c_o(alu_c_o)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] model(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        logic signed [31:0] sa, sb;
        sa = a;
        sb = b;
        case (op)
            4'h0: return a + b;
            4'h1: return a - b;
            4'h2: return a & b;
            4'h3: return a | b;
            4'h4: return a ^ b;
            4'h5: return a << b[4:0];
            4'h6: return a >> b[4:0];
            4'h7: return sa >>> b[4:0];
            4'h8: return (sa < sb) ? 32'd1 : 32'd0;
            4'h9: return (a < b) ? 32'd1 : 32'd0;
            4'hA: return a * b;
            4'hB: begin
                if (b == 0) return 32'hFFFFFFFF;
                if (a == 32'h80000000 && b == 32'hFFFFFFFF) return 32'h80000000;
                return sa / sb;
            end
            4'hC: return (b == 0) ? 32'hFFFFFFFF : a / b;
            4'hD: begin
                if (b == 0) return a;
                if (a == 32'h80000000 && b == 32'hFFFFFFFF) return 32'h0;
                return sa % sb;
            end
            4'hE: return (b == 0) ? a : a % b;
            default: return b;
        endcase
    endfunction

    // Drives one instruction, waits out any stall, then checks the EX/MEM result.
    task automatic run_op(input string tag, input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        int cyc;
        bit bub_bad;
        bit mc;
        logic [31:0] exp;
        mc = (op >= 4'hA && op <= 4'hE);
        alu_op_i = op; alua_i = a; alub_i = b;
        pc_i = $urandom; ext_i = $urandom; rD2_i = $urandom;
        wR_i = 5'($urandom); rf_wsel_i = 2'($urandom);
        rf_we_i = 1'b1; ram_we_i = 1'($urandom);
        exp = model(op, a, b);
        cyc = 0;
        bub_bad = 0;
        #1;
        while (pause_o === 1'b1 && cyc < 100) begin
            @(posedge clk_i); #1;
            cyc++;
            if (rf_we_o !== 1'b0 || ram_we_o !== 1'b0 || alu_c_o !== 32'h0) bub_bad = 1;
        end
        chk({tag, "_stall"}, cyc, mc ? 32'd33 : 32'd0);
        chk({tag, "_bubble"}, {31'h0, bub_bad}, 32'h0);
        @(posedge clk_i); #1;
        chk({tag, "_res"}, alu_c_o, exp);
        chk({tag, "_pc"}, pc_o, pc_i);
        chk({tag, "_ctl"}, {21'h0, wR_o, rf_wsel_o, rf_we_o, ram_we_o},
            {21'h0, wR_i, rf_wsel_i, rf_we_i, ram_we_i});
        chk({tag, "_ext"}, ext_o ^ rD2_o, ext_i ^ rD2_i);
    endtask

    task automatic abort_test(input bit use_rst);
        alu_op_i = 4'hB; alua_i = 32'hFFFFFFF9; alub_i = 32'd2;
        rf_we_i = 1'b1; ram_we_i = 1'b1; pc_i = 32'h1234;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk_i); #1;
        end
        if (use_rst) rst_i = 1'b1;
        else         flush_i = 1'b1;
        #1;
        if (!use_rst) chk("flush_pause", {31'h0, pause_o}, 32'h0);
        @(posedge clk_i); #1;
        chk(use_rst ? "rst_we" : "flush_we", {30'h0, rf_we_o, ram_we_o}, 32'h0);
        chk(use_rst ? "rst_res" : "flush_res", alu_c_o, 32'h0);
        chk(use_rst ? "rst_pc" : "flush_pc", pc_o, 32'h0);
        rst_i = 1'b0;
        flush_i = 1'b0;
        run_op(use_rst ? "post_rst_add" : "post_flush_add", 4'h0, 32'd20, 32'd22);
        run_op(use_rst ? "post_rst_div" : "post_flush_div", 4'hB, 32'hFFFFFFF9, 32'd2);
    endtask

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 5))
            0: return 32'h0;
            1: return 32'hFFFFFFFF;
            2: return 32'h80000000;
            default: return $urandom;
        endcase
    endfunction

    initial begin
        rst_i = 1'b1; flush_i = 1'b0; pc_i = 0; ram_we_i = 0; wR_i = 0;
        rf_wsel_i = 0; rf_we_i = 0; alu_op_i = 0; alua_i = 0; alub_i = 0;
        ext_i = 0; rD2_i = 0;
        repeat (3) @(posedge clk_i);
        #1;
        chk("rst_pause", {31'h0, pause_o}, 32'h0);
        chk("rst_alu_c", alu_c_o, 32'h0);
        chk("rst_ctl", {pc_o[31:9], wR_o, rf_wsel_o, rf_we_o, ram_we_o}, 32'h0);
        rst_i = 1'b0;

        run_op("add", 4'h0, 32'd5, 32'd7);
        run_op("sra", 4'h7, 32'h80000000, 32'd4);
        run_op("sltu", 4'h9, 32'd1, 32'hFFFFFFFF);
        run_op("slt", 4'h8, 32'hFFFFFFFF, 32'd1);
        run_op("div_neg", 4'hB, 32'hFFFFFFF9, 32'd2);
        run_op("rem_neg", 4'hD, 32'hFFFFFFF9, 32'd2);
        run_op("divu_z", 4'hC, 32'd9, 32'd0);
        run_op("remu_z", 4'hE, 32'd9, 32'd0);
        run_op("div_z_neg", 4'hB, 32'hFFFFFFF9, 32'd0);
        run_op("rem_z_neg", 4'hD, 32'hFFFFFFF9, 32'd0);
        run_op("div_ovf", 4'hB, 32'h80000000, 32'hFFFFFFFF);
        run_op("rem_ovf", 4'hD, 32'h80000000, 32'hFFFFFFFF);
        run_op("mul_wrap", 4'hA, 32'h10000, 32'h10000);
        run_op("mul_neg", 4'hA, 32'd123, 32'hFFFFFFFE);
        run_op("remu_big", 4'hE, 32'hFFFFFFFF, 32'd10);

        abort_test(1'b0);
        abort_test(1'b1);

        for (int i = 0; i < 40; i++)
            run_op("rand", 4'($urandom_range(0, 15)), pick(), pick());

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
